mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16; cycles allowed for mem_ready before an access aborts.
REQ-002 Parameter: DATA_W, default 32; data word width.
REQ-003 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-005 Ports: req0/req1  in  1  access request from CPU (0) and loader/DMA (1).
REQ-006 Ports: we0/we1  in  1  write strobe qualifying the request.
REQ-007 Ports: addr0/addr1  in  16  virtual address.
REQ-008 Ports: wdata0/wdata1  in  DATA_W  write data.
REQ-009 Ports: ack0/ack1  out  1  one-cycle completion pulse to the owning requester.
REQ-010 Ports: err0/err1  out  1  one-cycle error pulse, coincident with ack.
REQ-011 Port: rdata  out  DATA_W  read data, valid only in the ack cycle.
REQ-012 Ports: mem_addr  out  16; mem_we  out  1; mem_wdata  out  DATA_W; mem_valid  out  1  downstream access toward the address-translation unit.
REQ-013 Ports: mem_rdata  in  DATA_W; mem_ready  in  1  downstream completion; the UART window may stall.

Function
REQ-014 FSM states: IDLE, CHECK, ACCESS, DONE.
REQ-015 IDLE: if any req is high, latch the winner's addr/we/wdata and owner id, then go to CHECK.
REQ-016 Arbitration: round-robin. The last-served requester loses a tie. After reset, requester 0 wins a tie.
REQ-017 CHECK: a legal address is in one of three windows: data 0x0000-0x003F, stack 0x03C1-0x0400 (grows down), UART 0x0800-0x083F.
REQ-018 CHECK: an illegal address goes to DONE with the error flag set and no mem_valid.
REQ-019 CHECK: a legal address goes to ACCESS.
REQ-020 ACCESS: hold mem_valid=1 with latched mem_addr/mem_we/mem_wdata until mem_ready=1.
REQ-021 ACCESS: on mem_ready=1, capture mem_rdata and go to DONE.
REQ-022 DONE: pulse ack/err of the owner for exactly one cycle, drive rdata (zero on error or write), update last-served, go to IDLE.
REQ-023 Latency: legal access with mem_ready already high = 4 cycles from req sampled to ack. Illegal access = 3 cycles.
REQ-024 Handshake: requester holds req and its operands until ack. The arbiter ignores operand changes after latching.
REQ-025 Handshake: a requester dropping req before ack does not cancel an access in flight.
REQ-026 Exclusivity: ack0 and ack1 are never high in the same cycle. mem_valid is low outside ACCESS.
REQ-027 Both req high continuously: grants alternate 0,1,0,1...

Reset
REQ-028 rst_n low forces, immediately: state IDLE, last-served=1, all ack/err/mem_valid/mem_we=0, mem_addr/mem_wdata/rdata=0.
REQ-029 Reset during ACCESS abandons the transaction with no ack.
REQ-030 Operation resumes on the first rising edge after rst_n deasserts.

Configuration
REQ-031 Macro MEM_ARB_TIMEOUT_EN defined: a counter runs in ACCESS.
REQ-032 With the macro, after TIMEOUT_CYCLES cycles without mem_ready: drop mem_valid, go to DONE with the error flag set.
REQ-033 Macro undefined: no counter; ACCESS waits indefinitely.

Structure
REQ-034 Shared package mem_map_pkg holds: window base/limit constants (DATA/STACK/UART bases, BLOCK_SIZE=64) and the FSM state enum.
REQ-035 Sub-module addr_window_check: combinational legal/illegal decode from a 16-bit address, reused by the address-translation unit.

Verification
REQ-036 Single read: req0 alone, addr=0x0010, mem_ready=1, mem_rdata=0xDEADBEEF -> ack0 pulse 4 cycles later, rdata=0xDEADBEEF, err0=0.
REQ-037 Contention: req0 and req1 both high from reset, legal addrs -> service order 0,1,0,1; never both acks in one cycle.
REQ-038 Illegal address: req1 addr=0x0500 -> no mem_valid, ack1=err1=1 after 3 cycles, rdata=0.
REQ-039 UART stall: addr=0x0804, mem_ready low 5 cycles -> mem_valid held 6 cycles, single ack.
REQ-040 Timeout (macro on, TIMEOUT_CYCLES=16): mem_ready stuck low -> err pulse after 16 ACCESS cycles. Macro off: no ack.
REQ-041 Reset mid-access: rst_n low during ACCESS -> outputs zero immediately, no ack. Next request is served normally.

Source files
------------

// File: rtl/mem_map_pkg.sv
// rtl/mem_map_pkg.sv - address window constants and arbiter state encoding
package mem_map_pkg;

    localparam int          BLOCK_SIZE = 64;
    localparam logic [15:0] DATA_BASE  = 16'h0000;
    localparam logic [15:0] STACK_TOP  = 16'h0400;
    localparam logic [15:0] UART_BASE  = 16'h0800;
    // The stack grows down from STACK_TOP, so its lowest legal word sits one above TOP-BLOCK_SIZE
    localparam logic [15:0] STACK_BASE = STACK_TOP - 16'(BLOCK_SIZE) + 16'd1;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        ACCESS,
        DONE
    } arb_state_t;

    function automatic logic in_block(input logic [15:0] addr, input logic [15:0] base);
        logic [15:0] off;
        off = addr - base;
        return (addr >= base) && (off < 16'(BLOCK_SIZE));
    endfunction

endpackage

// File: rtl/addr_window_check.sv
// rtl/addr_window_check.sv - combinational legal-address decode over the data, stack and UART windows
module addr_window_check
    import mem_map_pkg::*;
(
    input  logic [15:0] addr,
    output logic        legal
);

    assign legal = in_block(addr, DATA_BASE)
                || in_block(addr, STACK_BASE)
                || in_block(addr, UART_BASE);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin memory arbiter with window check
// Optional ACCESS timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
    import mem_map_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int DATA_W         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [15:0]       addr0,
    input  logic [15:0]       addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata,
    output logic [15:0]       mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    arb_state_t        state;
    logic              owner;
    logic              last_served;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;
    logic              addr_legal;
    logic              pick1;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] tmo_cnt;
`endif

    // Requester 1 wins when alone, or on a tie when requester 0 was served last
    assign pick1 = req1 && (!req0 || !last_served);

    addr_window_check u_win (
        .addr  (mem_addr),
        .legal (addr_legal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last_served <= 1'b1;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            err0        <= 1'b0;
            err1        <= 1'b0;
            rdata       <= '0;
            mem_addr    <= '0;
            mem_we      <= 1'b0;
            mem_wdata   <= '0;
            mem_valid   <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
        end else begin
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            err0  <= 1'b0;
            err1  <= 1'b0;
            rdata <= '0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner     <= pick1;
                        mem_addr  <= pick1 ? addr1  : addr0;
                        mem_we    <= pick1 ? we1    : we0;
                        mem_wdata <= pick1 ? wdata1 : wdata0;
                        err_q     <= 1'b0;
                        state     <= CHECK;
                    end
                end
                CHECK: begin
                    if (addr_legal) begin
                        mem_valid <= 1'b1;
                        state     <= ACCESS;
`ifdef MEM_ARB_TIMEOUT_EN
                        tmo_cnt   <= '0;
`endif
                    end else begin
                        err_q <= 1'b1;
                        state <= DONE;
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        rdata_q   <= mem_rdata;
                        state     <= DONE;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        mem_valid <= 1'b0;
                        err_q     <= 1'b1;
                        state     <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    ack0        <= !owner;
                    ack1        <= owner;
                    err0        <= !owner && err_q;
                    err1        <= owner && err_q;
                    rdata       <= (err_q || mem_we) ? '0 : rdata_q;
                    last_served <= owner;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter against a transaction-level model
module tb_mem_arbiter;

    localparam int DW  = 32;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, req1, we0, we1;
    logic [15:0]   addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1, err0, err1;
    logic [DW-1:0] rdata;
    logic [15:0]   mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic          mem_valid;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    int checks = 0;
    int errors = 0;
    int last_served = 1;
    bit use_fixed = 1'b0;

    logic [15:0] bnd [12] = '{16'h0000, 16'h003F, 16'h0040, 16'h03C0, 16'h03C1, 16'h0400,
                              16'h0401, 16'h07FF, 16'h0800, 16'h083F, 16'h0840, 16'hFFFF};

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT_CYCLES(TMO), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1), .rdata(rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_valid(mem_valid),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    function automatic logic [31:0] resp(input logic [15:0] a);
        return {a ^ 16'hC3A5, ~a};
    endfunction

    function automatic logic [31:0] exp_resp(input logic [15:0] a);
        return use_fixed ? 32'hDEADBEEF : resp(a);
    endfunction

    assign mem_rdata = use_fixed ? 32'hDEADBEEF : resp(mem_addr);

    function automatic logic in_map(input logic [15:0] a);
        return (a <= 16'h003F) || (a >= 16'h03C1 && a <= 16'h0400) || (a >= 16'h0800 && a <= 16'h083F);
    endfunction

    function automatic logic [15:0] pick_addr();
        case ($urandom_range(0, 3))
            0:       return bnd[$urandom_range(0, 11)];
            1:       return 16'($urandom_range(0, 63)) | ($urandom_range(0, 1) != 0 ? 16'h0800 : 16'h0000);
            2:       return 16'h03C1 + 16'($urandom_range(0, 63));
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int who, input logic [15:0] a, input logic w, input logic [31:0] d);
        if (who == 0) begin req0 = 1'b1; addr0 = a; we0 = w; wdata0 = d; end
        else          begin req1 = 1'b1; addr1 = a; we1 = w; wdata1 = d; end
    endtask

    task automatic wait_ack(input int stall, input int bound, input bit mutate, input bit drop,
                            input logic [15:0] ea, input logic ewe, input logic [31:0] ewd,
                            output int cyc, output int vcnt, output logic a0, output logic a1,
                            output logic e0, output logic e1, output logic [31:0] rd, output logic ok);
        cyc = 0; vcnt = 0; a0 = 1'b0; a1 = 1'b0; e0 = 1'b0; e1 = 1'b0; rd = '0; ok = 1'b1;
        mem_ready = (stall == 0);
        while (cyc < bound) begin
            @(negedge clk);
            cyc++;
            if (ack0 && ack1) ok = 1'b0;
            if (mem_valid) begin
                vcnt++;
                if (mem_addr !== ea || mem_we !== ewe || mem_wdata !== ewd) ok = 1'b0;
                mem_ready = (vcnt > stall);
            end
            if (ack0 || ack1) begin
                a0 = ack0; a1 = ack1; e0 = err0; e1 = err1; rd = rdata;
                break;
            end
            if (mutate) begin
                addr0 = 16'($urandom); addr1 = 16'($urandom);
                wdata0 = $urandom; wdata1 = $urandom;
                we0 = ~we0; we1 = ~we1;
            end
            if (drop) begin req0 = 1'b0; req1 = 1'b0; end
        end
        mem_ready = 1'b0;
    endtask

    task automatic serve(input string tag, input int who, input logic [15:0] a, input logic w,
                         input logic [31:0] d, input int stall, input bit mutate, input bit drop);
        int cyc, vcnt, eff, ecyc, ev;
        logic a0, a1, e0, e1, ok, lg, eerr;
        logic [31:0] rd, erd;
        lg = in_map(a);
        eff = stall;
        eerr = !lg;
`ifdef MEM_ARB_TIMEOUT_EN
        if (lg && stall >= TMO) begin eff = TMO - 1; eerr = 1'b1; end
`endif
        ecyc = lg ? 4 + eff : 3;
        ev   = lg ? eff + 1 : 0;
        erd  = (eerr || w) ? 32'h0 : exp_resp(a);
        wait_ack(stall, 200, mutate, drop, a, w, d, cyc, vcnt, a0, a1, e0, e1, rd, ok);
        chk({tag, "_latency"},   32'(cyc), 32'(ecyc));
        chk({tag, "_valid_cyc"}, 32'(vcnt), 32'(ev));
        chk({tag, "_ack_own"},   32'(who == 0 ? a0 : a1), 32'd1);
        chk({tag, "_ack_other"}, 32'(who == 0 ? a1 : a0), 32'd0);
        chk({tag, "_err_own"},   32'(who == 0 ? e0 : e1), 32'(eerr));
        chk({tag, "_err_other"}, 32'(who == 0 ? e1 : e0), 32'd0);
        chk({tag, "_rdata"},     rd, erd);
        chk({tag, "_mem_bus"},   32'(ok), 32'd1);
        if (who == 0) req0 = 1'b0; else req1 = 1'b0;
        last_served = who;
    endtask

    task automatic dual(input string tag,
                        input logic [15:0] aa, input logic wa, input logic [31:0] da, input int sa,
                        input logic [15:0] ab, input logic wb, input logic [31:0] db, input int sb);
        int w;
        w = (last_served == 1) ? 0 : 1;
        set_req(0, aa, wa, da);
        set_req(1, ab, wb, db);
        if (w == 0) begin
            serve({tag, "_first0"}, 0, aa, wa, da, sa, 1'b0, 1'b0);
            serve({tag, "_then1"},  1, ab, wb, db, sb, 1'b0, 1'b0);
        end else begin
            serve({tag, "_first1"}, 1, ab, wb, db, sb, 1'b0, 1'b0);
            serve({tag, "_then0"},  0, aa, wa, da, sa, 1'b0, 1'b0);
        end
    endtask

    task automatic reset_mid();
        logic seen;
        chk("pre_reset_in_access", 32'(mem_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_mem_addr",  32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_we",    32'(mem_we), 32'd0);
        chk("rst_acks",      32'({ack0, ack1, err0, err1}), 32'd0);
        chk("rst_rdata",     rdata, 32'd0);
        req0 = 1'b0; req1 = 1'b0;
        seen = 1'b0;
        repeat (3) begin @(negedge clk); seen = seen | ack0 | ack1; end
        rst_n = 1'b1;
        last_served = 1;
        repeat (2) begin @(negedge clk); seen = seen | ack0 | ack1; end
        chk("rst_no_ack", 32'(seen), 32'd0);
    endtask

    initial begin
        int cyc, vcnt, who;
        logic a0, a1, e0, e1, ok, w;
        logic [31:0] rd, d;
        logic [15:0] a;

        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_acks",  32'({ack0, ack1, err0, err1}), 32'd0);
        chk("reset_valid", 32'({mem_valid, mem_we}), 32'd0);
        chk("reset_addr",  32'(mem_addr), 32'd0);
        chk("reset_wdata", mem_wdata, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        dual("contend_a", 16'h0004, 1'b0, 32'h11111111, 0, 16'h0808, 1'b0, 32'h22222222, 0);
        dual("contend_b", 16'h03F0, 1'b1, 32'h33333333, 1, 16'h0020, 1'b0, 32'h44444444, 0);

        use_fixed = 1'b1;
        set_req(0, 16'h0010, 1'b0, 32'h0);
        serve("single_read", 0, 16'h0010, 1'b0, 32'h0, 0, 1'b0, 1'b0);
        use_fixed = 1'b0;

        set_req(1, 16'h0020, 1'b1, 32'hCAFEF00D);
        serve("write", 1, 16'h0020, 1'b1, 32'hCAFEF00D, 0, 1'b0, 1'b0);

        set_req(1, 16'h0500, 1'b0, 32'h5);
        serve("illegal", 1, 16'h0500, 1'b0, 32'h5, 0, 1'b0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            set_req(i % 2, bnd[i], 1'b0, 32'(i));
            serve("boundary", i % 2, bnd[i], 1'b0, 32'(i), i % 3, 1'b0, 1'b0);
        end

        set_req(0, 16'h0804, 1'b0, 32'h0);
        serve("uart_stall", 0, 16'h0804, 1'b0, 32'h0, 5, 1'b0, 1'b0);

        set_req(0, 16'h0030, 1'b0, 32'h77);
        serve("operand_change", 0, 16'h0030, 1'b0, 32'h77, 2, 1'b1, 1'b0);

        set_req(1, 16'h0810, 1'b0, 32'h88);
        serve("req_dropped", 1, 16'h0810, 1'b0, 32'h88, 2, 1'b0, 1'b1);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) != 0) begin
                dual("rnd_dual", pick_addr(), 1'($urandom), $urandom, $urandom_range(0, 3),
                                 pick_addr(), 1'($urandom), $urandom, $urandom_range(0, 3));
            end else begin
                who = $urandom_range(0, 1);
                a = pick_addr();
                w = 1'($urandom);
                d = $urandom;
                set_req(who, a, w, d);
                serve("rnd_single", who, a, w, d, $urandom_range(0, 3), 1'b0, 1'b0);
            end
        end

`ifdef MEM_ARB_TIMEOUT_EN
        set_req(0, 16'h0804, 1'b0, 32'h0);
        serve("timeout", 0, 16'h0804, 1'b0, 32'h0, 1000, 1'b0, 1'b0);
        set_req(0, 16'h0008, 1'b0, 32'h9);
        wait_ack(1000, 5, 1'b0, 1'b0, 16'h0008, 1'b0, 32'h9, cyc, vcnt, a0, a1, e0, e1, rd, ok);
        chk("mid_access_no_ack", 32'({a0, a1}), 32'd0);
`else
        set_req(0, 16'h0804, 1'b0, 32'h0);
        wait_ack(1000, 40, 1'b0, 1'b0, 16'h0804, 1'b0, 32'h0, cyc, vcnt, a0, a1, e0, e1, rd, ok);
        chk("no_timeout_no_ack", 32'({a0, a1}), 32'd0);
        chk("no_timeout_valid",  32'(vcnt), 32'd39);
`endif
        reset_mid();

        set_req(1, 16'h03C8, 1'b0, 32'hAB);
        serve("post_reset", 1, 16'h03C8, 1'b0, 32'hAB, 1, 1'b0, 1'b0);
        dual("post_reset_tie", 16'h0001, 1'b0, 32'h1, 0, 16'h0002, 1'b0, 32'h2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
